button_toggle_4b: RTL and testbench

BUTTON_TOGGLE_4B -- requirements
Module: button_toggle_4b

---
 rtl/btn_pkg.sv | 16 +
 rtl/debounce_toggle_1b.sv | 101 ++++++++++
 rtl/button_toggle_4b.sv | 31 +++
 tb/tb_button_toggle_4b.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for push-button input blocks: debounce defaults,
// button count and the per-bit debounce FSM state encoding.
package btn_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
  localparam int unsigned CNT_W_DEF           = 20;
  localparam int unsigned NUM_BTN             = 4;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_e;

endpackage : btn_pkg

// File: rtl/debounce_toggle_1b.sv
// One button: 2-flop synchronizer, debounce FSM with stability counter,
// registered press pulse and a toggle flop flipped on each accepted press.
module debounce_toggle_1b
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic q,
  output logic pressed,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchronizer carries the active-high level, so a reset value of 0 means released.
  logic sync_meta;
  logic sync_lvl;

  btn_state_e       state;
  btn_state_e       state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             q_d;
  logic             pressed_d;
  logic             press_d;

  // State, counter, synchronizer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_lvl  <= 1'b0;
      state     <= ST_IDLE;
      cnt       <= '0;
      q         <= 1'b0;
      pressed   <= 1'b0;
      press     <= 1'b0;
    end else begin
      sync_meta <= ~btn_n;
      sync_lvl  <= sync_meta;
      state     <= state_d;
      cnt       <= cnt_d;
      q         <= q_d;
      pressed   <= pressed_d;
      press     <= press_d;
    end
  end

  // Next-state, counter and next-output logic.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    q_d     = q;
    press_d = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sync_lvl) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync_lvl) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          state_d = ST_HELD;
          press_d = 1'b1;
          q_d     = ~q;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (!sync_lvl) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        // A re-press here is release bounce: return to HELD silently.
        if (sync_lvl) begin
          state_d = ST_HELD;
        end else if (cnt == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    pressed_d = (state_d == ST_HELD) || (state_d == ST_RELEASE_WAIT);
  end

endmodule : debounce_toggle_1b

// File: rtl/button_toggle_4b.sv
// Four independent debounced push-buttons, each toggling one bit of q
// (operand word for the downstream 4-bit 2-to-1 mux).
module button_toggle_4b
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] q,
  output logic [NUM_BTN-1:0] pressed,
  output logic [NUM_BTN-1:0] press
);

  for (genvar i = 0; i < int'(NUM_BTN); i++) begin : g_bit
    debounce_toggle_1b #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .clk    (clk),
      .rst    (rst),
      .btn_n  (btn_n[i]),
      .q      (q[i]),
      .pressed(pressed[i]),
      .press  (press[i])
    );
  end

endmodule : button_toggle_4b

// File: tb/tb_button_toggle_4b.sv
// Bench for button_toggle_4b: directed scenarios plus random bouncing,
// compared every cycle against a run-length model of the debouncer.
module tb_button_toggle_4b;

  localparam int unsigned D = 4;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [3:0] btn_n = 4'hF;
  logic [3:0] q;
  logic [3:0] pressed;
  logic [3:0] press;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: level flips after D+1 consecutive synced samples disagree with it.
  logic [3:0] m_s1    = '0;
  logic [3:0] m_s2    = '0;
  logic [3:0] m_level = '0;
  logic [3:0] m_q     = '0;
  logic [3:0] m_press = '0;
  int         m_run [4];

  button_toggle_4b #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (20)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_n  (btn_n),
    .q      (q),
    .pressed(pressed),
    .press  (press)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
  endtask

  task automatic model_edge();
    m_press = '0;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_q = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == int'(D) + 1) begin
            m_level[i] = ~m_level[i];
            m_run[i]   = 0;
            if (m_level[i]) begin
              m_q[i]     = ~m_q[i];
              m_press[i] = 1'b1;
            end
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = ~btn_n;
    end
  endtask

  task automatic step(input logic r, input logic [3:0] b);
    rst   = r;
    btn_n = b;
    @(posedge clk);
    model_edge();
    #1;
    check("q", q, m_q);
    check("pressed", pressed, m_level);
    check("press", press, m_press);
  endtask

  initial begin
    int first;
    int last;
    int npulse;
    int nall;
    logic [3:0] b;
    logic       pressed_drop;

    for (int i = 0; i < 4; i++) m_run[i] = 0;

    // Reset with all buttons held, then every bit toggles once.
    step(1'b1, 4'h0);
    step(1'b1, 4'h0);
    check("rst_q", q, 4'h0);
    check("rst_pressed", pressed, 4'h0);
    check("rst_press", press, 4'h0);
    first = -1; npulse = 0;
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 4'h0);
      if (press != 4'h0) npulse++;
      if (first < 0 && q == 4'hF) first = k;
    end
    check_int("rst_toggle_edge", first, 2 + int'(D));
    check_int("rst_toggle_pulses", npulse, 1);
    for (int k = 0; k < 12; k++) step(1'b0, 4'hF);
    check("rst_release_q", q, 4'hF);
    step(1'b1, 4'hF);
    step(1'b1, 4'hF);

    // Clean press on bit 0.
    first = -1; npulse = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 4'hE);
      if (press[0]) begin
        npulse++;
        if (first < 0) first = k;
      end
    end
    check_int("clean_edge", first, 2 + int'(D));
    check_int("clean_pulses", npulse, 1);
    check("clean_q", q, 4'h1);
    last = -1;
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 4'hF);
      if (pressed[0]) last = k;
    end
    check_int("clean_release_last", last, 2 + int'(D) - 1);

    // Press bounce on bit 1.
    npulse = 0;
    for (int k = 0; k < 23; k++) begin
      step(1'b0, (k < 2 || (k >= 3 && k < 13)) ? 4'hD : 4'hF);
      if (press[1]) npulse++;
    end
    check_int("bounce_pulses", npulse, 1);
    check("bounce_q", q, 4'h3);

    // Release bounce on bit 2 while held.
    npulse = 0; pressed_drop = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 4'hB);
      if (press[2]) npulse++;
    end
    for (int k = 0; k < 10; k++) begin
      step(1'b0, (k < 2) ? 4'hF : 4'hB);
      if (press[2]) npulse++;
      if (!pressed[2]) pressed_drop = 1'b1;
    end
    check_int("relbounce_pulses", npulse, 1);
    check_int("relbounce_pressed_drop", int'(pressed_drop), 0);
    check("relbounce_q", q, 4'h7);
    for (int k = 0; k < 12; k++) step(1'b0, 4'hF);

    // Simultaneous press from q = 0101.
    step(1'b1, 4'hF);
    step(1'b1, 4'hF);
    for (int k = 0; k < 8; k++) step(1'b0, 4'hA);
    for (int k = 0; k < 12; k++) step(1'b0, 4'hF);
    check("simul_pre_q", q, 4'h5);
    npulse = 0; nall = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 4'h0);
      if (press != 4'h0) npulse++;
      if (press == 4'hF) nall++;
    end
    check_int("simul_pulse_cycles", npulse, 1);
    check_int("simul_all_cycles", nall, 1);
    check("simul_q", q, 4'hA);
    for (int k = 0; k < 12; k++) step(1'b0, 4'hF);

    // Reset in the middle of a bit-3 debounce, button still held.
    step(1'b1, 4'hF);
    step(1'b1, 4'hF);
    npulse = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 4'h7);
      if (press != 4'h0) npulse++;
    end
    check_int("midrst_pre_pulses", npulse, 0);
    step(1'b1, 4'h7);
    check("midrst_q", q, 4'h0);
    check("midrst_pressed", pressed, 4'h0);
    first = -1; npulse = 0;
    for (int k = 0; k < 14; k++) begin
      step(1'b0, 4'h7);
      if (press != 4'h0) npulse++;
      if (first < 0 && q[3]) first = k;
    end
    check_int("midrst_toggle_edge", first, 2 + int'(D));
    check_int("midrst_pulses", npulse, 1);
    check("midrst_q_after", q, 4'h8);

    // Random bouncing with occasional resets.
    b = 4'hF;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 9) == 0) b[i] = ~b[i];
      step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_button_toggle_4b
